// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: applies one single-bit step per clock.
// Ports: clk, reset, start, in_data, shift_type, amount, inverse -> out_data, carry, busy, done.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       shift_type,
  input  logic [AMT_W-1:0] amount,
  input  logic             inverse,
  output logic [WIDTH-1:0] out_data,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ROL  = 3'b001;
  localparam logic [2:0] OP_ROR  = 3'b010;
  localparam logic [2:0] OP_LSL  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_LSR  = 3'b101;

  state_t           state;
  state_t           state_next;
  logic [2:0]       op;
  logic [2:0]       eff;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] step_d;
  logic             step_c;

  // Effective operation; codes 110/111 collapse to none.
  always_comb begin
    eff = OP_NONE;
    case (shift_type)
      OP_ROL: eff = inverse ? OP_ROR : OP_ROL;
      OP_ROR: eff = inverse ? OP_ROL : OP_ROR;
      OP_LSL: eff = inverse ? OP_LSR : OP_LSL;
      OP_ASR: eff = inverse ? OP_LSL : OP_ASR;
      OP_LSR: eff = inverse ? OP_LSL : OP_LSR;
      default: eff = OP_NONE;
    endcase
  end

  // One single-bit step of the latched operation.
  always_comb begin
    step_d = out_data;
    step_c = carry;
    case (op)
      OP_ROL: begin
        step_d = {out_data[WIDTH-2:0], out_data[WIDTH-1]};
        step_c = out_data[WIDTH-1];
      end
      OP_ROR: begin
        step_d = {out_data[0], out_data[WIDTH-1:1]};
        step_c = out_data[0];
      end
      OP_LSL: begin
        step_d = {out_data[WIDTH-2:0], 1'b0};
        step_c = out_data[WIDTH-1];
      end
      OP_ASR: begin
        step_d = {out_data[WIDTH-1], out_data[WIDTH-1:1]};
        step_c = out_data[0];
      end
      OP_LSR: begin
        step_d = {1'b0, out_data[WIDTH-1:1]};
        step_c = out_data[0];
      end
      default: begin
        step_d = out_data;
        step_c = carry;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (amount == '0 || eff == OP_NONE)
            state_next = DONE;
          else
            state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == AMT_W'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      op       <= OP_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            out_data <= in_data;
            carry    <= 1'b0;
            cnt      <= amount;
            op       <= eff;
          end
        end
        SHIFT: begin
          out_data <= step_d;
          carry    <= step_c;
          cnt      <= cnt - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver pushes expected results,
// monitor pops and compares whenever done is presented.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic [2:0] shift_type;
  logic [2:0] amount;
  logic       inverse;
  logic [7:0] out_data;
  logic       carry;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int brun = 0;

  typedef struct {
    logic [7:0] d;
    logic       c;
    int         n;
    int         e0;
  } exp_t;

  exp_t q[$];

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_data(in_data),
    .shift_type(shift_type),
    .amount(amount),
    .inverse(inverse),
    .out_data(out_data),
    .carry(carry),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Closed-form result of n steps of the effective operation.
  function automatic exp_t model(logic [7:0] d, logic [2:0] t,
                                 logic [2:0] a, logic inv);
    exp_t e;
    int   op;
    int   n;
    int   x;
    int   sx;
    int   r;
    x = int'(d);
    case (t)
      3'd1: op = inv ? 2 : 1;
      3'd2: op = inv ? 1 : 2;
      3'd3: op = inv ? 5 : 3;
      3'd4: op = inv ? 3 : 4;
      3'd5: op = inv ? 3 : 5;
      default: op = 0;
    endcase
    n = (op == 0) ? 0 : int'(a);
    e.d = d;
    e.c = 1'b0;
    e.n = n;
    e.e0 = 0;
    r = x;
    if (n > 0) begin
      case (op)
        1: begin
          r = ((x << n) | (x >> (8 - n))) & 255;
          e.c = r[0];
        end
        2: begin
          r = ((x >> n) | (x << (8 - n))) & 255;
          e.c = r[7];
        end
        3: begin
          r = (x << n) & 255;
          e.c = x[8-n];
        end
        4: begin
          sx = x[7] ? x - 256 : x;
          r = (sx >>> n) & 255;
          e.c = x[n-1];
        end
        default: begin
          r = x >> n;
          e.c = x[n-1];
        end
      endcase
      e.d = r[7:0];
    end
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b0) begin
      brun = 0;
    end else begin
      brun = busy ? brun + 1 : 0;
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("carry", 32'(carry), 32'(e.c));
          chk("latency", 32'(cyc - e.e0), 32'(e.n));
          chk("busy_len", 32'(brun), 32'(e.n + 1));
        end
      end
    end
  end

  task automatic issue(logic [7:0] d, logic [2:0] t, logic [2:0] a,
                       logic inv, bit junk);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (busy !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      chk("idle_timeout", 32'(busy), 32'd0);
      return;
    end
    start = 1'b1;
    in_data = d;
    shift_type = t;
    amount = a;
    inverse = inv;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(d, t, a, inv);
    e.e0 = cyc;
    q.push_back(e);
    in_data = 8'($urandom);
    shift_type = 3'($urandom);
    amount = 3'($urandom);
    inverse = 1'($urandom);
    if (junk) begin
      @(negedge clk);
      start = 1'b1;
      in_data = 8'h55;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    in_data = '0;
    shift_type = '0;
    amount = '0;
    inverse = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    issue(8'h96, 3'd1, 3'd3, 1'b0, 1'b0);
    issue(8'hB4, 3'd1, 3'd3, 1'b1, 1'b0);
    issue(8'h96, 3'd4, 3'd2, 1'b0, 1'b0);
    issue(8'h96, 3'd5, 3'd7, 1'b0, 1'b1);
    issue(8'h96, 3'd3, 3'd0, 1'b0, 1'b0);
    issue(8'h96, 3'd7, 3'd5, 1'b0, 1'b0);

    // Asynchronous reset mid-operation discards the result.
    issue(8'h96, 3'd1, 3'd5, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_carry", 32'(carry), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    q.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      issue(8'($urandom), 3'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
